// File: rtl/piano_disp_pkg.sv
// Shared definitions for the piano display path: arbiter state encoding,
// display word width, one-second hold length and a blank code for status sources.
package piano_disp_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SHOW = 1'b1
   } disp_state_e;

   localparam int DISP_W  = 16;
   localparam int HOLD_1S = 25_000_000;

   localparam logic [DISP_W-1:0] DISP_BLANK = 16'hFFFF;

endpackage

// File: rtl/seg7_disp_arbiter_rr_arbiter.sv
// Round-robin search: the first set request strictly after 'last', wrapping modulo N_REQ.
// Tying 'last' to N_REQ-1 turns it into a lowest-index-wins priority encoder.
module rr_arbiter #(
   parameter int N_REQ = 3
) (
   input  logic [N_REQ-1:0] req,
   input  logic [1:0]       last,
   output logic [N_REQ-1:0] gnt,
   output logic [1:0]       gnt_id,
   output logic             any
);

   always_comb begin
      gnt    = '0;
      gnt_id = '0;
      any    = 1'b0;
      // Walk offsets from farthest to nearest so the nearest set bit is the one kept.
      for (int k = N_REQ; k >= 1; k--) begin
         if (req[(int'(last) + k) % N_REQ]) begin
            gnt_id = 2'((int'(last) + k) % N_REQ);
            any    = 1'b1;
         end
      end
      if (any) gnt[gnt_id] = 1'b1;
   end

endmodule

// File: rtl/seg7_disp_arbiter.sv
// Shares one 4-digit seg7 display among N_REQ requesters with a timed hold.
// Define SEG7_ARB_FIXED_PRIO_EN for fixed, preemptive priority instead of round-robin.
module seg7_disp_arbiter
   import piano_disp_pkg::*;
#(
   parameter int N_REQ       = 3,
   parameter int HOLD_CYCLES = HOLD_1S,
   parameter int CNT_W       = 25
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req,
   input  logic [DISP_W*N_REQ-1:0] req_data,
   input  logic [DISP_W-1:0]       idle_num,
   output logic [N_REQ-1:0]        ack,
   output logic [DISP_W-1:0]       display_num,
   output logic                    busy,
   output logic [1:0]              grant_id
);

   disp_state_e       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DISP_W-1:0] disp_q, disp_d;
   logic [N_REQ-1:0]  ack_q, ack_d;
   logic [1:0]        gid_q, gid_d;

   logic [N_REQ-1:0]  req_m;
   logic [N_REQ-1:0]  win_gnt;
   logic [1:0]        win_id;
   logic              win_any;
   logic [1:0]        arb_last;
   logic              grant_en;
   logic [1:0]        grant_sel;
   logic [N_REQ-1:0]  grant_vec;

   // A requester still sees its ack this cycle and cannot have dropped req yet.
   assign req_m = req & ~ack_q;

`ifdef SEG7_ARB_FIXED_PRIO_EN
   assign arb_last = 2'(N_REQ - 1);
`else
   logic [1:0] last_q, last_d;
   assign arb_last = last_q;
`endif

   rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .req    (req_m),
      .last   (arb_last),
      .gnt    (win_gnt),
      .gnt_id (win_id),
      .any    (win_any)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      disp_d    = disp_q;
      ack_d     = '0;
      gid_d     = gid_q;
      grant_en  = 1'b0;
      grant_sel = win_id;
      grant_vec = win_gnt;
`ifndef SEG7_ARB_FIXED_PRIO_EN
      last_d    = last_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (win_any) grant_en = 1'b1;
            else         disp_d   = idle_num;
         end
         default: begin
`ifdef SEG7_ARB_FIXED_PRIO_EN
            // Same-index win is a refresh, lower index preempts.
            if (win_any && (win_id <= gid_q)) begin
               grant_en = 1'b1;
            end else
`else
            if (req_m[gid_q]) begin
               grant_en  = 1'b1;
               grant_sel = gid_q;
               grant_vec = N_REQ'(1) << gid_q;
            end else
`endif
            if (cnt_q == '0) begin
               if (win_any) begin
                  grant_en = 1'b1;
               end else begin
                  state_d = ST_IDLE;
                  disp_d  = idle_num;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
      endcase

      if (grant_en) begin
         state_d = ST_SHOW;
         cnt_d   = CNT_W'(HOLD_CYCLES - 1);
         disp_d  = req_data[DISP_W*grant_sel +: DISP_W];
         ack_d   = grant_vec;
         gid_d   = grant_sel;
`ifndef SEG7_ARB_FIXED_PRIO_EN
         last_d  = grant_sel;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         disp_q  <= '0;
         ack_q   <= '0;
         gid_q   <= '0;
`ifndef SEG7_ARB_FIXED_PRIO_EN
         last_q  <= 2'(N_REQ - 1);
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         disp_q  <= disp_d;
         ack_q   <= ack_d;
         gid_q   <= gid_d;
`ifndef SEG7_ARB_FIXED_PRIO_EN
         last_q  <= last_d;
`endif
      end
   end

   assign ack         = ack_q;
   assign display_num = disp_q;
   assign busy        = (state_q == ST_SHOW);
   assign grant_id    = gid_q;

endmodule

// File: tb/tb_seg7_disp_arbiter.sv
// Bench for seg7_disp_arbiter: directed sequences, an idle-tracking vector table and
// random requester traffic checked against a per-cycle behavioural model.
module tb_seg7_disp_arbiter;

   localparam int N    = 3;
   localparam int HOLD = 8;

   logic          clk;
   logic          rst;
   logic [N-1:0]  req;
   logic [16*N-1:0] req_data;
   logic [15:0]   idle_num;
   logic [N-1:0]  ack, ack1;
   logic [15:0]   disp, disp1;
   logic          busy, busy1;
   logic [1:0]    gid, gid1;

   seg7_disp_arbiter #(.N_REQ(N), .HOLD_CYCLES(HOLD), .CNT_W(4)) u_dut (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data), .idle_num(idle_num),
      .ack(ack), .display_num(disp), .busy(busy), .grant_id(gid)
   );

   seg7_disp_arbiter #(.N_REQ(N), .HOLD_CYCLES(1), .CNT_W(1)) u_dut1 (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data), .idle_num(idle_num),
      .ack(ack1), .display_num(disp1), .busy(busy1), .grant_id(gid1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit rand_phase = 1'b0;

   // Behavioural model: who is on the display, how many shown cycles remain.
   logic [N-1:0] m_ack = '0, m_ack_seen = '0;
   logic [15:0]  m_disp = '0;
   logic         m_busy = 1'b0;
   int           m_gid = 0, m_remain = 0, m_last = N - 1;

   task automatic m_grant(input int w);
      m_disp    = req_data[16*w +: 16];
      m_ack     = '0;
      m_ack[w]  = 1'b1;
      m_gid     = w;
      m_last    = w;
      m_busy    = 1'b1;
      m_remain  = HOLD;
   endtask

   always @(posedge clk) begin : model
      logic [N-1:0] eff;
      int w;
      m_ack_seen = m_ack;
      eff = req & ~m_ack;
      if (rst) begin
         m_disp = '0; m_ack = '0; m_busy = 1'b0; m_gid = 0; m_remain = 0; m_last = N - 1;
      end else begin
         m_ack = '0;
         w = -1;
`ifdef SEG7_ARB_FIXED_PRIO_EN
         for (int i = N - 1; i >= 0; i--) if (eff[i]) w = i;
`else
         for (int k = N; k >= 1; k--) if (eff[(m_last + k) % N]) w = (m_last + k) % N;
`endif
         if (!m_busy) begin
            if (w >= 0) m_grant(w);
            else        m_disp = idle_num;
         end else begin
`ifdef SEG7_ARB_FIXED_PRIO_EN
            if (w >= 0 && w <= m_gid) m_grant(w);
`else
            if (eff[m_gid]) m_grant(m_gid);
`endif
            else if (m_remain == 1) begin
               if (w >= 0) m_grant(w);
               else begin m_busy = 1'b0; m_disp = idle_num; end
            end else begin
               m_remain = m_remain - 1;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drop every req whose ack was visible during the cycle just ended.
   task automatic autodrop();
      for (int i = 0; i < N; i++)
         if (req[i] && m_ack_seen[i])
            if (!(rand_phase && $urandom_range(0, 7) == 0)) req[i] = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      chk("model_disp", 32'(disp), 32'(m_disp));
      chk("model_ack",  32'(ack),  32'(m_ack));
      chk("model_busy", 32'(busy), 32'(m_busy));
      if (m_busy) chk("model_gid", 32'(gid), 32'(m_gid));
      autodrop();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      tick();
      rst = 1'b0;
   endtask

   typedef struct {
      logic [15:0] idle;
      logic [15:0] exp_disp;
   } idle_vec_t;

   idle_vec_t vecs[6];
   int b, n, gap, c0;
   int gids[3], cycs[3];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{16'h1234, 16'h1234};
      vecs[1] = '{16'h0000, 16'h0000};
      vecs[2] = '{16'h9999, 16'h9999};
      vecs[3] = '{16'hFFFF, 16'hFFFF};
      vecs[4] = '{16'h0A5F, 16'h0A5F};
      vecs[5] = '{16'h4321, 16'h4321};

      rst = 1'b1; req = '0; req_data = '0; idle_num = 16'h1234;

      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_disp", 32'(disp), 32'h0);
         chk("rst_busy", 32'(busy), 32'h0);
         chk("rst_ack",  32'(ack),  32'h0);
         chk("rst_gid",  32'(gid),  32'h0);
      end
      rst = 1'b0;
      tick();
      chk("idle_first", 32'(disp), 32'h1234);

      foreach (vecs[i]) begin
         idle_num = vecs[i].idle;
         tick();
         chk("idle_track", 32'(disp), 32'(vecs[i].exp_disp));
         chk("idle_busy",  32'(busy), 32'h0);
      end

      // Single grant, full hold length
      idle_num = 16'h1234;
      req[1] = 1'b1; req_data[16 +: 16] = 16'h0567;
      tick();
      chk("single_ack",  32'(ack),  32'h2);
      chk("single_disp", 32'(disp), 32'h0567);
      chk("single_gid",  32'(gid),  32'h1);
      chk("single_busy", 32'(busy), 32'h1);
      b = 1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (busy) b++;
         else break;
      end
      chk("single_busy_len", 32'(b), 32'(HOLD));
      chk("single_back_idle", 32'(disp), 32'h1234);

      // HOLD_CYCLES=1 instance: exactly one shown cycle
      do_reset();
      req[1] = 1'b1; req_data[16 +: 16] = 16'h0321;
      tick();
      chk("h1_ack",  32'(ack1),  32'h2);
      chk("h1_busy", 32'(busy1), 32'h1);
      chk("h1_disp", 32'(disp1), 32'h0321);
      tick();
      chk("h1_busy_off", 32'(busy1), 32'h0);
      chk("h1_disp_idle", 32'(disp1), 32'(idle_num));
      for (int i = 0; i < 10; i++) tick();

`ifndef SEG7_ARB_FIXED_PRIO_EN
      // Round-robin back-to-back
      do_reset();
      req = 3'b111;
      req_data = {16'h0222, 16'h0111, 16'h0000};
      n = 0; gap = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (n > 0 && n < 3 && !busy) gap++;
         if (ack != '0 && n < 3) begin
            gids[n] = int'(gid); cycs[n] = c; n++;
         end
      end
      chk("rr_count", 32'(n), 32'h3);
      chk("rr_g0", 32'(gids[0]), 32'h0);
      chk("rr_g1", 32'(gids[1]), 32'h1);
      chk("rr_g2", 32'(gids[2]), 32'h2);
      chk("rr_space01", 32'(cycs[1] - cycs[0]), 32'(HOLD));
      chk("rr_space12", 32'(cycs[2] - cycs[1]), 32'(HOLD));
      chk("rr_gap", 32'(gap), 32'h0);

      // Refresh at counter=3 restarts a full hold; requester 0 waits
      do_reset();
      req[2] = 1'b1; req_data[32 +: 16] = 16'h0222;
      tick();
      chk("ref_first_ack", 32'(ack), 32'h4);
      for (int i = 0; i < 4; i++) tick();
      req[2] = 1'b1; req_data[32 +: 16] = 16'h0009;
      req[0] = 1'b1; req_data[0 +: 16]  = 16'h0AAA;
      tick();
      chk("ref_ack",  32'(ack),  32'h4);
      chk("ref_disp", 32'(disp), 32'h0009);
      chk("ref_gid",  32'(gid),  32'h2);
      c0 = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (ack[0]) begin c0 = i; break; end
      end
      chk("ref_wait", 32'(c0), 32'(HOLD));

      // Refresh colliding with expiry while requester 0 is pending
      do_reset();
      req[1] = 1'b1; req_data[16 +: 16] = 16'h0111;
      tick();
      chk("col_first_ack", 32'(ack), 32'h2);
      tick();
      req[0] = 1'b1; req_data[0 +: 16] = 16'h0A0A;
      for (int i = 0; i < 6; i++) tick();
      req[1] = 1'b1; req_data[16 +: 16] = 16'h0BBB;
      tick();
      chk("col_ack",  32'(ack),  32'h2);
      chk("col_gid",  32'(gid),  32'h1);
      chk("col_disp", 32'(disp), 32'h0BBB);
      c0 = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (ack[0]) begin c0 = i; break; end
      end
      chk("col_wait", 32'(c0), 32'(HOLD));
`else
      // Fixed priority preemption
      do_reset();
      req[2] = 1'b1; req_data[32 +: 16] = 16'h0222;
      tick();
      chk("fp_first_gid", 32'(gid), 32'h2);
      tick();
      req[0] = 1'b1; req_data[0 +: 16] = 16'h0AAA;
      tick();
      chk("fp_ack",  32'(ack),  32'h1);
      chk("fp_disp", 32'(disp), 32'h0AAA);
      chk("fp_gid",  32'(gid),  32'h0);
`endif

      // Reset in the middle of a hold with a request pending
      do_reset();
      req[0] = 1'b1; req_data[0 +: 16] = 16'h0707;
      tick(); tick(); tick();
      rst = 1'b1;
      req[1] = 1'b1; req_data[16 +: 16] = 16'h0808;
      tick();
      chk("mrst_disp", 32'(disp), 32'h0);
      chk("mrst_ack",  32'(ack),  32'h0);
      chk("mrst_busy", 32'(busy), 32'h0);
      chk("mrst_gid",  32'(gid),  32'h0);
      tick();
      chk("mrst_ack2", 32'(ack), 32'h0);
      rst = 1'b0;
      tick();
      chk("mrst_after_ack", 32'(ack), 32'h2);

      // Random traffic against the model
      for (int i = 0; i < 20; i++) tick();
      rand_phase = 1'b1;
      for (int c = 0; c < 2000; c++) begin
         tick();
         for (int i = 0; i < N; i++) begin
            if (!req[i] && $urandom_range(0, 5) == 0) begin
               req_data[16*i +: 16] = 16'($urandom);
               req[i] = 1'b1;
            end
         end
         if ($urandom_range(0, 3) == 0) idle_num = 16'($urandom);
         rst = ($urandom_range(0, 199) == 0);
      end
      rst = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
